// File: rtl/video_colorizer_if.sv
// Signal bundle between the OLED raster generator / settings source and the
// video_colorizer output stage that feeds the Pocket video scaler.
interface video_colorizer_if;
  logic        v_sync;
  logic        h_sync;
  logic        video_en;
  logic        video;
  logic [1:0]  palette_sel;
  logic        invert;
  logic        scanlines;
  logic [2:0]  scaler_slot;
  logic [23:0] video_rgb;
  logic        video_de;
  logic        video_hs;
  logic        video_vs;
  logic [15:0] frame_count;
  logic [8:0]  line_pixels;

  modport master (
    output v_sync, h_sync, video_en, video,
    output palette_sel, invert, scanlines, scaler_slot,
    input  video_rgb, video_de, video_hs, video_vs,
    input  frame_count, line_pixels
  );

  modport slave (
    input  v_sync, h_sync, video_en, video,
    input  palette_sel, invert, scanlines, scaler_slot,
    output video_rgb, video_de, video_hs, video_vs,
    output frame_count, line_pixels
  );
endinterface

// File: rtl/video_colorizer.sv
// Pixel-clock output stage: colours the raster generator's 1-bit pixel and
// delays the sync/enable strobes by two cycles for the Pocket video scaler.
module video_colorizer #(
  parameter int PIPE_LATENCY = 2
) (
  input logic              clk_pixel,
  input logic              reset,
  video_colorizer_if.slave bus
);
  localparam logic [6:0] ROW_MAX = 7'd127;
  localparam logic [8:0] COL_MAX = 9'd511;

  if (PIPE_LATENCY != 2) begin : g_latency_check
    $error("video_colorizer supports only PIPE_LATENCY = 2");
  end

  typedef struct packed {
    logic [1:0] palette;
    logic       invert;
    logic       scanlines;
    logic [2:0] slot;
  } settings_t;

  // Returns {lit, unlit}.
  function automatic logic [47:0] palette_colors(input logic [1:0] sel);
    case (sel)
      2'd0:    return {24'hFFFFFF, 24'h000000};
      2'd1:    return {24'hFFB000, 24'h100800};
      2'd2:    return {24'h33FF33, 24'h001000};
      default: return {24'h40C0FF, 24'h000818};
    endcase
  endfunction

  settings_t   shadow;
  settings_t   eff;
  logic        en_prev;
  logic        fall;
  logic [6:0]  row;
  logic [6:0]  row_eff;
  logic [8:0]  col;
  logic [23:0] lit;
  logic [23:0] unlit;

  logic        s1_de;
  logic        s1_hs;
  logic        s1_vs;
  logic        s1_half;
  logic [23:0] s1_rgb;
  logic [2:0]  s1_slot;

  // A v_sync pixel already uses the settings and row it latches.
  // NOTE: every output of this block is assigned on every pass, so no latch is inferred.
  always_comb begin
    eff            = bus.v_sync ? {bus.palette_sel, bus.invert, bus.scanlines, bus.scaler_slot}
                                : shadow;
    row_eff        = bus.v_sync ? 7'd0 : row;
    fall           = en_prev & ~bus.video_en;
    {lit, unlit}   = palette_colors(eff.palette);
  end

  // Stage 1: settings shadow, counters, palette lookup.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      shadow          <= '0;
      en_prev         <= 1'b0;
      row             <= '0;
      col             <= '0;
      bus.frame_count <= '0;
      bus.line_pixels <= '0;
      s1_de           <= 1'b0;
      s1_hs           <= 1'b0;
      s1_vs           <= 1'b0;
      s1_half         <= 1'b0;
      s1_rgb          <= '0;
      s1_slot         <= '0;
    end else begin
      en_prev <= bus.video_en;

      if (bus.v_sync) begin
        shadow          <= eff;
        bus.frame_count <= bus.frame_count + 16'd1;
      end

      if (bus.v_sync)
        row <= '0;
      else if (fall && row != ROW_MAX)
        row <= row + 7'd1;

      if (fall) begin
        bus.line_pixels <= col;
        col             <= '0;
      end else if (bus.h_sync) begin
        col <= '0;
      end else if (bus.video_en && col != COL_MAX) begin
        col <= col + 9'd1;
      end

      s1_de   <= bus.video_en;
      s1_hs   <= bus.h_sync;
      s1_vs   <= bus.v_sync;
      s1_rgb  <= (bus.video ^ eff.invert) ? lit : unlit;
      // Halving follows the lit pixel, which shows the unlit palette entry when inverted.
      s1_half <= bus.video & eff.scanlines & row_eff[0];
      s1_slot <= eff.slot;
    end
  end

  // Stage 2: scanline dimming and blanking, with the slot word on the DE falling cycle.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      bus.video_rgb <= '0;
      bus.video_de  <= 1'b0;
      bus.video_hs  <= 1'b0;
      bus.video_vs  <= 1'b0;
    end else begin
      bus.video_de <= s1_de;
      bus.video_hs <= s1_hs;
      bus.video_vs <= s1_vs;
      if (s1_de)
        bus.video_rgb <= s1_half ? ((s1_rgb >> 1) & 24'h7F7F7F) : s1_rgb;
      else if (bus.video_de)
        bus.video_rgb <= {21'd0, s1_slot};
      else
        bus.video_rgb <= '0;
    end
  end
endmodule

// File: tb/tb_video_colorizer.sv
// Directed bench for video_colorizer: a vector table through the two-stage
// pipeline plus hand sequences for counters, saturation, reset and wrap.
module tb_video_colorizer;
  typedef struct {
    logic        vs;
    logic        hs;
    logic        en;
    logic        vid;
    logic [1:0]  pal;
    logic        inv;
    logic        scan;
    logic [2:0]  slot;
    logic [23:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_fc = 0;

  vec_t p1, p2, zero_v;
  bit   v1, v2;
  vec_t tbl [27];

  video_colorizer_if bus ();

  video_colorizer #(.PIPE_LATENCY(2)) dut (
    .clk_pixel (clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic vs, input logic hs, input logic en, input logic vid,
                              input logic [1:0] pal, input logic inv, input logic scan,
                              input logic [2:0] slot, input logic [23:0] rgb);
    vec_t v;
    v.vs = vs; v.hs = hs; v.en = en; v.vid = vid;
    v.pal = pal; v.inv = inv; v.scan = scan; v.slot = slot; v.rgb = rgb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.v_sync      = v.vs;
    bus.h_sync      = v.hs;
    bus.video_en    = v.en;
    bus.video       = v.vid;
    bus.palette_sel = v.pal;
    bus.invert      = v.inv;
    bus.scanlines   = v.scan;
    bus.scaler_slot = v.slot;
  endtask

  // Checks the output due from two steps ago, then drives this step's inputs.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    if (v2)
      check(tag, {bus.video_rgb, bus.video_de, bus.video_hs, bus.video_vs},
                 {p2.rgb, p2.en, p2.hs, p2.vs});
    p2 = p1; v2 = v1;
    p1 = v;  v1 = 1'b1;
    if (v.vs) exp_fc = (exp_fc + 1) & 16'hFFFF;
    drive(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, bus.video_rgb, 24'h0);
    check({tag, "_sync"}, {bus.video_de, bus.video_hs, bus.video_vs}, 3'b000);
    check({tag, "_frame_count"}, bus.frame_count, 16'h0);
    check({tag, "_line_pixels"}, bus.line_pixels, 9'h0);
  endtask

  initial begin
    zero_v = mk(0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 24'h0);

    //               vs hs en vid pal inv scn slot  rgb
    tbl[0]  = mk(0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 24'h000000);
    tbl[1]  = mk(1, 0, 0, 0, 2'd2, 0, 1, 3'd5, 24'h000000);
    tbl[2]  = mk(0, 1, 0, 0, 2'd2, 0, 1, 3'd5, 24'h000000);
    tbl[3]  = mk(0, 0, 1, 1, 2'd2, 0, 1, 3'd5, 24'h33FF33);
    tbl[4]  = mk(0, 0, 1, 0, 2'd2, 0, 1, 3'd5, 24'h001000);
    tbl[5]  = mk(0, 0, 1, 1, 2'd2, 0, 1, 3'd5, 24'h33FF33);
    tbl[6]  = mk(0, 0, 0, 0, 2'd2, 0, 1, 3'd5, 24'h000005);
    tbl[7]  = mk(0, 0, 0, 0, 2'd2, 0, 1, 3'd5, 24'h000000);
    tbl[8]  = mk(0, 1, 0, 0, 2'd2, 0, 1, 3'd5, 24'h000000);
    tbl[9]  = mk(0, 0, 1, 1, 2'd2, 0, 1, 3'd5, 24'h197F19);
    tbl[10] = mk(0, 0, 1, 0, 2'd2, 0, 1, 3'd5, 24'h001000);
    tbl[11] = mk(0, 0, 0, 0, 2'd2, 0, 1, 3'd5, 24'h000005);
    tbl[12] = mk(0, 0, 0, 0, 2'd1, 1, 0, 3'd3, 24'h000000);
    tbl[13] = mk(0, 1, 0, 0, 2'd1, 1, 0, 3'd3, 24'h000000);
    tbl[14] = mk(0, 0, 1, 1, 2'd1, 1, 0, 3'd3, 24'h33FF33);
    tbl[15] = mk(0, 0, 1, 0, 2'd1, 1, 0, 3'd3, 24'h001000);
    tbl[16] = mk(0, 0, 0, 0, 2'd1, 1, 0, 3'd3, 24'h000005);
    tbl[17] = mk(1, 0, 1, 1, 2'd1, 1, 0, 3'd3, 24'h100800);
    tbl[18] = mk(0, 0, 1, 0, 2'd1, 1, 0, 3'd3, 24'hFFB000);
    tbl[19] = mk(0, 0, 0, 0, 2'd1, 1, 0, 3'd3, 24'h000003);
    tbl[20] = mk(0, 0, 0, 0, 2'd1, 1, 0, 3'd3, 24'h000000);
    tbl[21] = mk(1, 0, 0, 0, 2'd3, 0, 1, 3'd0, 24'h000000);
    tbl[22] = mk(0, 0, 1, 1, 2'd3, 0, 1, 3'd0, 24'h40C0FF);
    tbl[23] = mk(0, 0, 1, 0, 2'd3, 0, 1, 3'd0, 24'h000818);
    tbl[24] = mk(0, 0, 0, 0, 2'd3, 0, 1, 3'd0, 24'h000000);
    tbl[25] = mk(0, 0, 1, 1, 2'd3, 0, 1, 3'd0, 24'h20607F);
    tbl[26] = mk(0, 0, 0, 0, 2'd3, 0, 1, 3'd0, 24'h000000);

    // Power-on reset
    reset = 1'b1;
    drive(zero_v);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;
    p1 = zero_v; p2 = zero_v; v1 = 1'b1; v2 = 1'b1;

    // Table: palettes, invert, scanlines, mid-frame changes, slot word
    for (int i = 0; i < 27; i++) step(tbl[i], $sformatf("tbl%0d", i));
    step(zero_v, "tbl_drain0");
    step(zero_v, "tbl_drain1");
    check("tbl_frame_count", bus.frame_count, 16'(exp_fc));
    check("tbl_line_pixels", bus.line_pixels, 9'd1);

    // 256-pixel alternating line on palette 0, then column saturation
    step(mk(1, 0, 0, 0, 2'd0, 0, 0, 3'd0, 24'h0), "alt_vs");
    for (int i = 0; i < 256; i++)
      step(mk(0, 0, 1, ~i[0], 2'd0, 0, 0, 3'd0, i[0] ? 24'h000000 : 24'hFFFFFF), "alt_px");
    step(zero_v, "alt_fall");
    @(posedge clk); #1;
    check("line_pixels_256", bus.line_pixels, 9'd256);
    step(mk(0, 1, 0, 0, 2'd0, 0, 0, 3'd0, 24'h0), "sat_hs");
    for (int i = 0; i < 600; i++)
      step(mk(0, 0, 1, 1, 2'd0, 0, 0, 3'd0, 24'hFFFFFF), "sat_px");
    step(zero_v, "sat_fall");
    @(posedge clk); #1;
    check("line_pixels_sat", bus.line_pixels, 9'd511);

    // Row counter saturates at 127 (odd, so scanlines keep halving)
    step(mk(1, 0, 0, 0, 2'd0, 0, 1, 3'd0, 24'h0), "row_vs");
    for (int r = 0; r < 130; r++) begin
      int row_m;
      row_m = (r > 127) ? 127 : r;
      step(mk(0, 0, 1, 1, 2'd0, 0, 1, 3'd0, row_m[0] ? 24'h7F7F7F : 24'hFFFFFF),
           $sformatf("row%0d", r));
      step(mk(0, 0, 0, 0, 2'd0, 0, 1, 3'd0, 24'h0), "row_fall");
    end

    // Two small frames: strobes are delayed copies, frame_count tracks v_sync
    for (int f = 0; f < 2; f++) begin
      for (int y = 0; y < 12; y++) begin
        for (int x = 0; x < 40; x++) begin
          logic en, vid;
          en  = (y >= 2 && y < 10 && x >= 8 && x < 32);
          vid = ((x + y) % 3) == 0;
          step(mk((x == 0 && y == 0), (x < 3), en, vid, 2'd0, 0, 0, 3'd0,
                  (en && vid) ? 24'hFFFFFF : 24'h0), "frame");
        end
      end
      check($sformatf("frame%0d_count", f), bus.frame_count, 16'(exp_fc));
    end

    // Reset mid-active-line; defaults hold until the next v_sync
    step(mk(0, 1, 0, 0, 2'd0, 0, 0, 3'd0, 24'h0), "mid_hs");
    for (int i = 0; i < 3; i++) step(mk(0, 0, 1, 1, 2'd0, 0, 0, 3'd0, 24'hFFFFFF), "mid_px");
    #2;
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 2'd3, 1, 1, 3'd6, 24'h0));
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    p1 = zero_v; p2 = zero_v; v1 = 1'b1; v2 = 1'b1; exp_fc = 0;
    step(mk(0, 0, 1, 1, 2'd3, 1, 1, 3'd6, 24'hFFFFFF), "post_lit");
    step(mk(0, 0, 1, 0, 2'd3, 1, 1, 3'd6, 24'h000000), "post_unlit");
    step(mk(0, 0, 0, 0, 2'd3, 1, 1, 3'd6, 24'h000000), "post_fall");
    step(mk(0, 0, 1, 1, 2'd3, 1, 1, 3'd6, 24'hFFFFFF), "post_row1");
    step(mk(0, 0, 0, 0, 2'd3, 1, 1, 3'd6, 24'h000000), "post_fall1");
    step(mk(1, 0, 0, 0, 2'd3, 1, 1, 3'd6, 24'h000000), "post_vs");
    step(mk(0, 0, 1, 1, 2'd3, 1, 1, 3'd6, 24'h000818), "post_inv_lit");
    step(mk(0, 0, 1, 0, 2'd3, 1, 1, 3'd6, 24'h40C0FF), "post_inv_unlit");
    step(mk(0, 0, 0, 0, 2'd3, 1, 1, 3'd6, 24'h000006), "post_slot");
    step(zero_v, "post_drain0");
    step(zero_v, "post_drain1");
    check("post_frame_count", bus.frame_count, 16'(exp_fc));

    // frame_count wraps FFFF -> 0000
    @(negedge clk);
    reset = 1'b1;
    drive(zero_v);
    @(negedge clk);
    reset = 1'b0;
    bus.v_sync = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("fc_ffff", bus.frame_count, 16'hFFFF);
    @(posedge clk);
    #1;
    check("fc_wrap", bus.frame_count, 16'h0000);
    @(negedge clk);
    bus.v_sync = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/video_colorizer.md
# video_colorizer

Pixel-clock output stage directly downstream of the OLED raster generator. It takes the raster generator's registered 1-bit monochrome pixel and sync/enable strobes and produces the 24-bit RGB, DE, HS and VS signals driven to the Pocket video scaler. Its other jobs:
- frame-latched palette, invert and scanline-effect settings;
- active-area row/column tracking;
- the scaler-slot control word emitted in blanking.

## Interface
Parameters:
- PIPE_LATENCY, 2, fixed cycles from input strobe to output; only 2 is supported.

Ports:
- clk_pixel  in  1  pixel clock, same clock as the raster generator.
- reset  in  1  **asynchronous, active-high** reset.
- v_sync  in  1  one-cycle frame-start strobe from the raster generator.
- h_sync  in  1  one-cycle line-start strobe.
- video_en  in  1  active-area qualifier.
- video  in  1  pixel value, 1 = lit, valid when video_en = 1.
- palette_sel  in  2  palette request, sampled at frame start.
- invert  in  1  swap lit/unlit colours, sampled at frame start.
- scanlines  in  1  halve lit colour on odd active rows, sampled at frame start.
- scaler_slot  in  3  Pocket scaler slot index, sampled at frame start.
- video_rgb  out  24  {R,G,B}, 8 bits each.
- video_de  out  1  delayed video_en.
- video_hs  out  1  delayed h_sync.
- video_vs  out  1  delayed v_sync.
- frame_count  out  16  count of v_sync strobes; wraps FFFF to 0000.
- line_pixels  out  9  active-pixel count of the most recently completed line.

## Operation
Settings latch:
- On any cycle with v_sync = 1, capture palette_sel, invert, scanlines and scaler_slot into shadow registers.
- The shadow registers drive the whole following frame.
- Input changes mid-frame have no effect.

Palettes (lit / unlit):
- 0: FFFFFF / 000000
- 1: FFB000 / 100800
- 2: 33FF33 / 001000
- 3: 40C0FF / 000818

Pixel colour:
- invert = 1 swaps lit and unlit before the scanline step.
- Scanline step: if scanlines = 1 and row[0] = 1, the selected lit colour is halved per channel (each byte >> 1). The unlit colour is never modified.

Row counter (7 bits):
- Cleared to 0 on v_sync.
- Incremented on each 1→0 transition of video_en.
- Saturates at 127.

Column counter (9 bits):
- Counts cycles with video_en = 1 and saturates at 511.
- On a 1→0 transition of video_en, its value is copied to line_pixels and the counter clears.
- Also cleared on h_sync.

Blanking output:
- When the delayed de = 0, video_rgb = 000000.
- Exception: on the single output cycle where video_de falls (first blanking cycle after an active line), video_rgb = {21'b0, scaler_slot_shadow}. This is the scaler control word.

frame_count increments on each v_sync.

Simultaneous events:
- v_sync with video_en = 1: row clears first, and the pixel is coloured as row 0 with the newly latched settings.
- h_sync with video_en falling: line_pixels captures the count, then the counter clears.

## Timing
- All outputs are registered.
- video_rgb, video_de, video_hs and video_vs lag their inputs by exactly 2 clk_pixel cycles:
  - Stage 1: register inputs, update counters, perform the palette lookup.
  - Stage 2: apply scanline and blank muxing.
- Sync pulse widths are preserved exactly.
- Shadow settings captured at cycle t are used for a pixel entering at t (same-cycle bypass) and for all later pixels.
- frame_count and line_pixels update 1 cycle after the triggering input edge.
- Reset values (asserted asynchronously, immediately):
  - Outputs: video_rgb = 0, video_de/hs/vs = 0, frame_count = 0, line_pixels = 0.
  - Shadows: palette 0, invert 0, scanlines 0, slot 0.
  - Counters: 0.
  - Pipeline: flushed to blanking.
- Reset mid-frame: after release, output is blanking until inputs resume; the power-on defaults stay in force until the next v_sync.

## Test plan
- Palette 0, no invert, video_en held high for 256 cycles with video alternating 1,0 → video_rgb alternates FFFFFF/000000 starting 2 cycles after the first video_en. line_pixels = 256 one cycle after video_en falls.
- palette_sel = 1 and invert = 1 applied mid-frame → no colour change until next v_sync. From the first active pixel after v_sync, lit = 100800 and unlit = FFB000.
- scanlines = 1, palette 2, lit pixels on rows 0 and 1 → row 0 = 33FF33, row 1 = 197F19. Unlit = 001000 on both rows.
- scaler_slot = 5 latched, then end of an active line → exactly one cycle of video_rgb = 000005 at the video_de falling cycle, 000000 on all other blanking cycles.
- Full frame of 416×147 cycles from the raster generator → video_vs/hs/de are bit-exact copies of the inputs delayed by 2. frame_count increments by 1 per frame and wraps from FFFF to 0000.
- Reset asserted mid-active-line → all outputs are 0 within the same cycle. After release, the first frame renders with palette 0, no invert and no scanlines until a v_sync latches new settings.
